// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Optional build macro DIV_BY_ZERO_CHK_EN: short-circuit a zero divisor straight to DONE.
`timescale 1ns/1ps

module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only in IDLE (busy=0); operands are captured at that
  // same edge. done pulses for exactly one cycle while results become valid; results
  // then hold until the next done. A start seen while busy=1 is dropped.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] r_sub;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             ge;
  logic             last_iter;

  // The stored remainder is always < D, so it fits in WIDTH bits; only the shifted
  // value needs the extra bit for the compare.
  always_comb begin
    r_shift   = {r_reg, q_reg[WIDTH-1]};
    ge        = (r_shift >= {1'b0, d_reg});
    r_sub     = r_shift[WIDTH-1:0] - d_reg;
    r_next    = ge ? r_sub : r_shift[WIDTH-1:0];
    q_next    = {q_reg[WIDTH-2:0], ge};
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_BY_ZERO_CHK_EN
          if (divisor == '0) state_next = DONE;
          else               state_next = CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            cnt   <= '0;
`ifdef DIV_BY_ZERO_CHK_EN
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
            end
`endif
          end
        end
        CALC: begin
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt + CW'(1);
          if (last_iter) begin
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_BY_ZERO_CHK_EN
  logic dbz_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      dbz_reg <= 1'b0;
    end else if (state == IDLE && start) begin
      if (divisor == '0) dbz_reg <= 1'b1;
    end else if (state == CALC && last_iter) begin
      dbz_reg <= 1'b0;
    end
  end

  assign div_by_zero = dbz_reg;
`else
  assign div_by_zero = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule
